// File: rtl/sinc_decimator_mc.sv
// sinc_decimator_mc: multi-channel sincN (CIC) decimator for 1-bit sigma-delta
// bitstreams. ORDER integrators run at the bitstream rate. A run-time
// power-of-two decimator feeds ORDER pipelined combs, which then fill a
// single-entry ready/valid output buffer. Start-up results are suppressed
// until the filter has settled.
module sinc_decimator_mc #(
  parameter int NCH          = 2,
  parameter int ORDER        = 3,
  parameter int LOG2_OSR_MAX = 6,
  parameter int OUT_W        = ORDER*LOG2_OSR_MAX+1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 bit_en,
  input  logic [NCH-1:0]                       din,
  input  logic [$clog2(LOG2_OSR_MAX+1)-1:0]    osr_sel,
  output logic [NCH*OUT_W-1:0]                 dout,
  output logic                                 dout_valid,
  input  logic                                 dout_ready,
  output logic                                 overrun,
  output logic                                 settling
);

  localparam int OSR_W    = $clog2(LOG2_OSR_MAX+1);
  localparam int CNT_W    = LOG2_OSR_MAX;
  localparam int SETTLE_N = ORDER + 1;
  localparam int SC_W     = $clog2(SETTLE_N+1);

  logic [OSR_W-1:0]       osr_clamped;
  logic [OSR_W-1:0]       osr_reg;
  logic [OSR_W-1:0]       osr_d_reg;
  logic                   flush;

  logic [CNT_W-1:0]       dec_cnt_reg;
  logic [CNT_W-1:0]       cnt_max;
  logic                   dec_last;
  logic                   capture;

  // stg_vld_reg[s] is high the cycle after comb stage s produced a new value
  logic [ORDER-1:0]       stg_vld_reg;
  logic                   new_result;
  logic [NCH*OUT_W-1:0]   result_bus;

  logic [NCH*OUT_W-1:0]   dout_reg;
  logic                   dout_valid_reg;
  logic                   overrun_reg;
  logic                   settling_reg;
  logic [SC_W-1:0]        settle_cnt_reg;

  // Force the requested ratio into the legal range 1..LOG2_OSR_MAX
  always_comb begin
    osr_clamped = osr_sel;
    if (osr_sel == '0)
      osr_clamped = OSR_W'(1);
    else if (osr_sel > OSR_W'(LOG2_OSR_MAX))
      osr_clamped = OSR_W'(LOG2_OSR_MAX);
  end

  // Register the ratio and keep a delayed copy. Reset loads both copies so
  // that leaving reset never causes a spurious flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      osr_reg   <= osr_clamped;
      osr_d_reg <= osr_clamped;
    end else begin
      osr_reg   <= osr_clamped;
      osr_d_reg <= osr_reg;
    end
  end

  // A ratio change restarts the whole filter one clk after it is registered
  assign flush = (osr_reg != osr_d_reg);

  // Terminal count of the decimation counter is R-1 = 2^osr - 1
  always_comb begin
    cnt_max = CNT_W'((32'd1 << osr_reg) - 32'd1);
  end

  assign dec_last = (dec_cnt_reg == cnt_max);
  assign capture  = bit_en && dec_last;

  // Count bit_en pulses 0..R-1 and wrap on the capturing pulse
  always_ff @(posedge clk) begin
    if (rst || flush)
      dec_cnt_reg <= '0;
    else if (bit_en)
      dec_cnt_reg <= dec_last ? '0 : dec_cnt_reg + CNT_W'(1);
  end

  // Walk the decimated-sample marker through the comb pipeline
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stg_vld_reg <= '0;
    end else begin
      stg_vld_reg[0] <= capture;
      for (int s = 1; s < ORDER; s++)
        stg_vld_reg[s] <= stg_vld_reg[s-1];
    end
  end

  assign new_result = stg_vld_reg[ORDER-1];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [OUT_W-1:0] integ_reg   [ORDER];
      logic [OUT_W-1:0] cmb_out_reg [ORDER];
      logic [OUT_W-1:0] cmb_dly_reg [ORDER];

      // Integrator cascade. Each stage adds the previous stage's registered
      // value, and the sum wraps modulo 2^OUT_W.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          for (int j = 0; j < ORDER; j++)
            integ_reg[j] <= '0;
        end else if (bit_en) begin
          integ_reg[0] <= integ_reg[0] + {{(OUT_W-1){1'b0}}, din[gi]};
          for (int j = 1; j < ORDER; j++)
            integ_reg[j] <= integ_reg[j] + integ_reg[j-1];
        end
      end

      // Comb pipeline. Stage 0 differentiates the captured integrator
      // value, and each later stage fires one clk after its predecessor.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          for (int s = 0; s < ORDER; s++) begin
            cmb_out_reg[s] <= '0;
            cmb_dly_reg[s] <= '0;
          end
        end else begin
          if (capture) begin
            cmb_dly_reg[0] <= integ_reg[ORDER-1];
            cmb_out_reg[0] <= integ_reg[ORDER-1] - cmb_dly_reg[0];
          end
          for (int s = 1; s < ORDER; s++) begin
            if (stg_vld_reg[s-1]) begin
              cmb_dly_reg[s] <= cmb_out_reg[s-1];
              cmb_out_reg[s] <= cmb_out_reg[s-1] - cmb_dly_reg[s];
            end
          end
        end
      end

      assign result_bus[gi*OUT_W +: OUT_W] = cmb_out_reg[ORDER-1];
    end
  endgenerate

  // Settling suppression and the single-entry output buffer. A flush keeps
  // the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      settling_reg   <= 1'b1;
      settle_cnt_reg <= '0;
    end else if (flush) begin
      dout_valid_reg <= 1'b0;
      settling_reg   <= 1'b1;
      settle_cnt_reg <= '0;
    end else if (new_result) begin
      if (settle_cnt_reg < SC_W'(SETTLE_N)) begin
        settle_cnt_reg <= settle_cnt_reg + SC_W'(1);
      end else begin
        dout_reg       <= result_bus;
        dout_valid_reg <= 1'b1;
        settling_reg   <= 1'b0;
        if (dout_valid_reg && !dout_ready)
          overrun_reg <= 1'b1;
      end
    end else if (dout_valid_reg && dout_ready) begin
      dout_valid_reg <= 1'b0;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign overrun    = overrun_reg;
  assign settling   = settling_reg;

endmodule

// File: tb/tb_sinc_decimator_mc.sv
// Directed bench for sinc_decimator_mc (NCH=2, ORDER=3, LOG2_OSR_MAX=6).
// bit_en is pulsed every 8 clk. Outputs are sampled 1 ns after each clock edge.
module tb_sinc_decimator_mc;

  localparam int NCH          = 2;
  localparam int ORDER        = 3;
  localparam int LOG2_OSR_MAX = 6;
  localparam int OUT_W        = 19;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 bit_en;
  logic [NCH-1:0]       din;
  logic [2:0]           osr_sel;
  logic [NCH*OUT_W-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 overrun;
  logic                 settling;

  int n_checks = 0;
  int n_errors = 0;
  int nbits    = 0;
  int n_out    = 0;

  // Values captured relative to the bit_en cycle t
  logic                 v_t3, v_t4, v_t5, s_t3, s_t4, o_t4;
  logic [NCH*OUT_W-1:0] d_t4;

  sinc_decimator_mc #(
    .NCH(NCH),
    .ORDER(ORDER),
    .LOG2_OSR_MAX(LOG2_OSR_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bit_en(bit_en),
    .din(din),
    .osr_sel(osr_sel),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overrun(overrun),
    .settling(settling)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bitstream sample: bit_en in cycle t, then idle until cycle t+8
  task automatic do_bit(input logic [NCH-1:0] bits);
    bit_en = 1'b1;
    din    = bits;
    step();
    bit_en = 1'b0;
    nbits++;
    step();
    step();
    v_t3 = dout_valid;
    s_t3 = settling;
    step();
    v_t4 = dout_valid;
    s_t4 = settling;
    o_t4 = overrun;
    d_t4 = dout;
    if (v_t4) begin
      n_out++;
      $display("out %0d: bit %0d ch0=%0d ch1=%0d settling=%0d overrun=%0d",
               n_out, nbits, d_t4[0 +: OUT_W], d_t4[OUT_W +: OUT_W], s_t4, o_t4);
    end
    step();
    v_t5 = dout_valid;
    repeat (3) step();
  endtask

  // Constant 1 at R=4 from a clean start: the first output is at bit 20
  task automatic const_start_seq(input string tag);
    for (int k = 1; k <= 24; k++) begin
      do_bit(2'b11);
      check({tag, "_valid"}, v_t4, (k == 20 || k == 24));
      if (k % 4 == 0 && k < 20)
        check({tag, "_settling_hold"}, s_t4, 1);
      if (k == 20) begin
        check({tag, "_valid_t3"}, v_t3, 0);
        check({tag, "_settling_t3"}, s_t3, 1);
        check({tag, "_settling_fall"}, s_t4, 0);
        check({tag, "_overrun"}, o_t4, 0);
        check({tag, "_ch0"}, d_t4[0 +: OUT_W], 64);
        check({tag, "_ch1"}, d_t4[OUT_W +: OUT_W], 64);
        check({tag, "_consumed"}, v_t5, 0);
      end
      if (k == 24)
        check({tag, "_ch0_next"}, d_t4[0 +: OUT_W], 64);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bit_en     = 1'b0;
    din        = '0;
    osr_sel    = 3'd2;
    dout_ready = 1'b1;
    repeat (3) step();
    check("reset_dout", dout, 0);
    check("reset_valid", dout_valid, 0);
    check("reset_overrun", overrun, 0);
    check("reset_settling", settling, 1);
    rst   = 1'b0;
    nbits = 0;

    // Start-up with constant 1
    const_start_seq("s1");

    // Alternating 1,0 on ch0, zero on ch1: 32 / 0 every 4 bits
    for (int k = 1; k <= 28; k++) begin
      do_bit({1'b0, k[0]});
      check("s2_spacing", v_t4, (nbits % 4 == 0));
      if (k > 16 && nbits % 4 == 0) begin
        check("s2_ch0", d_t4[0 +: OUT_W], 32);
        check("s2_ch1", d_t4[OUT_W +: OUT_W], 0);
      end
    end

    // Back to constant 1, then hold an output unconsumed
    for (int k = 1; k <= 12; k++) do_bit(2'b11);
    dout_ready = 1'b0;
    for (int k = 1; k <= 4; k++) do_bit(2'b11);
    check("s4_first_valid", v_t4, 1);
    check("s4_first_ch0", d_t4[0 +: OUT_W], 64);
    check("s4_first_held", v_t5, 1);
    for (int k = 1; k <= 3; k++) begin
      do_bit(2'b11);
      check("s4_hold", v_t4, 1);
    end
    // Acceptance in exactly the cycle the next result is loaded
    bit_en = 1'b1;
    din    = 2'b11;
    step();
    bit_en = 1'b0;
    nbits++;
    step();
    step();
    check("s4_pre_valid", dout_valid, 1);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("s4_same_cycle_valid", dout_valid, 1);
    check("s4_same_cycle_ch0", dout[0 +: OUT_W], 64);
    check("s4_same_cycle_overrun", overrun, 0);
    step();
    check("s4_new_held", dout_valid, 1);
    dout_ready = 1'b1;
    step();
    check("s4_accept", dout_valid, 0);
    repeat (2) step();

    // Overrun: ready low across two decimation instants
    dout_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      do_bit(2'b11);
      if (k == 4) begin
        check("s3_first_valid", v_t4, 1);
        check("s3_first_overrun", o_t4, 0);
      end
      if (k == 8) begin
        check("s3_valid", v_t4, 1);
        check("s3_ch0", d_t4[0 +: OUT_W], 64);
        check("s3_overrun", o_t4, 1);
      end
    end

    // Ratio change 2 -> 6: flush one clk after the registered change
    osr_sel = 3'd6;
    step();
    check("s5_pre_flush_valid", dout_valid, 1);
    check("s5_pre_flush_settling", settling, 0);
    step();
    check("s5_flush_valid", dout_valid, 0);
    check("s5_flush_settling", settling, 1);
    check("s5_flush_keeps_overrun", overrun, 1);
    dout_ready = 1'b1;
    step();
    check("s3_sticky_after_ready", overrun, 1);
    nbits = 0;
    for (int k = 1; k <= 320; k++) begin
      do_bit(2'b11);
      if (nbits % 64 == 0)
        check("s5_valid", v_t4, (nbits == 320));
      if (nbits == 256)
        check("s5_settling_hold", s_t4, 1);
      if (nbits == 320) begin
        check("s5_ch0", d_t4[0 +: OUT_W], 262144);
        check("s5_ch1", d_t4[OUT_W +: OUT_W], 262144);
        check("s5_settling_fall", s_t4, 0);
        check("s5_overrun", o_t4, 1);
      end
    end

    // osr_sel=7 clamps to 6: no flush, output continues at R=64
    osr_sel = 3'd7;
    for (int k = 1; k <= 64; k++) do_bit(2'b11);
    check("clamp_valid", v_t4, 1);
    check("clamp_ch0", d_t4[0 +: OUT_W], 262144);

    // Reset between two bit_en pulses in the middle of a decimation window
    do_bit(2'b11);
    do_bit(2'b11);
    repeat (3) step();
    osr_sel = 3'd2;
    rst     = 1'b1;
    step();
    check("s6_dout", dout, 0);
    check("s6_valid", dout_valid, 0);
    check("s6_overrun", overrun, 0);
    check("s6_settling", settling, 1);
    rst   = 1'b0;
    nbits = 0;
    const_start_seq("s6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
